vga_fb_bus_writer: RTL and testbench

//  Parametrised bus-mapped framebuffer write engine for the VGA subsystem; successor to the fixed 3-register VGA bus port.

---
 rtl/vga_fb_pkg.sv | 19 +
 rtl/vga_fb_bus_writer_if.sv | 13 +
 rtl/vga_fb_pointer.sv | 33 +++
 rtl/vga_fb_bus_writer.sv | 143 ++++++++++++++
 tb/tb_vga_fb_bus_writer.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_fb_pkg.sv
// Shared constants for the VGA framebuffer bus writer: register map, CTRL bits and FSM encoding.
package vga_fb_pkg;

    localparam logic [2:0] REG_PTR_HI = 3'd0;
    localparam logic [2:0] REG_PTR_LO = 3'd1;
    localparam logic [2:0] REG_DATA   = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_CNT_LO = 3'd4;
    localparam logic [2:0] REG_CNT_HI = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;
    localparam logic [2:0] REG_RSVD   = 3'd7;

    localparam int CTRL_AINC_BIT = 0;
    localparam int CTRL_GO_BIT   = 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

endpackage

// File: rtl/vga_fb_bus_writer_if.sv
// 8-bit processor bus seen by the framebuffer writer; the host's tristate driver lives here.
interface vga_fb_bus_writer_if;
    logic [7:0] bus_addr;
    logic       bus_we;
    logic [7:0] host_data;
    logic       host_oe;
    wire  [7:0] bus_data;

    assign bus_data = host_oe ? host_data : 8'hzz;

    modport master (output bus_addr, output bus_we, output host_data, output host_oe, input bus_data);
    modport slave  (input bus_addr, input bus_we, inout bus_data);
endinterface

// File: rtl/vga_fb_pointer.sv
// Loadable framebuffer pointer; increments wrap to 0 from FB_DEPTH-1 or from any out-of-range value.
module vga_fb_pointer #(
    parameter int FB_ADDR_W = 15,
    parameter int FB_DEPTH  = 19200
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_hi,
    input  logic                 load_lo,
    input  logic [7:0]           load_data,
    input  logic                 inc,
    output logic [FB_ADDR_W-1:0] ptr
);
    logic [FB_ADDR_W-1:0] ptr_reg;
    logic [FB_ADDR_W-1:0] ptr_next;
    logic                 at_end;

    assign at_end   = 32'(ptr_reg) >= 32'(FB_DEPTH - 1);
    assign ptr_next = at_end ? '0 : ptr_reg + FB_ADDR_W'(1);
    assign ptr      = ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_reg <= '0;
        end else if (load_hi) begin
            ptr_reg[FB_ADDR_W-1:8] <= load_data[FB_ADDR_W-9:0];
        end else if (load_lo) begin
            ptr_reg[7:0] <= load_data;
        end else if (inc) begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/vga_fb_bus_writer.sv
// Bus-mapped framebuffer write engine with auto-increment pointer and linear FILL.
// Optional register readback on the bus is enabled by defining VGA_FB_READBACK_EN.
module vga_fb_bus_writer
    import vga_fb_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR = 8'hB0,
    parameter int         FB_ADDR_W = 15,
    parameter int         FB_DEPTH  = 19200,
    parameter int         PIX_W     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    vga_fb_bus_writer_if.slave   bus,
    output logic [FB_ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]     fb_data,
    output logic                 fb_we,
    output logic                 busy
);
    logic [8:0]           addr_diff;
    logic                 in_range;
    logic [2:0]           offset;
    logic [7:0]           wdata;
    logic                 wr_acc;
    logic                 wr_cfg;
    logic                 go;
    logic                 data_emit;
    logic                 fill_emit;
    logic [FB_ADDR_W-1:0] ptr;

    logic [0:0]           state_reg, state_next;
    logic                 busy_reg;
    logic                 ainc_reg;
    logic [PIX_W-1:0]     colour_reg;
    logic [15:0]          fill_cnt_reg;
    logic [FB_ADDR_W-1:0] fb_addr_reg;
    logic [PIX_W-1:0]     fb_data_reg;
    logic                 fb_we_reg;

    // A 9-bit difference makes addresses below BASE_ADDR underflow out of range.
    assign addr_diff = {1'b0, bus.bus_addr} - {1'b0, BASE_ADDR};
    assign in_range  = addr_diff < 9'd8;
    assign offset    = addr_diff[2:0];
    assign wdata     = bus.bus_data;
    assign wr_acc    = bus.bus_we && in_range;
    assign wr_cfg    = wr_acc && !busy_reg;

    assign go        = wr_cfg && (offset == REG_CTRL) && wdata[CTRL_GO_BIT] && (fill_cnt_reg != 16'd0);
    assign data_emit = wr_cfg && (offset == REG_DATA);
    // The first fill pixel leaves on the GO edge so FILL has the same latency as a DATA write.
    assign fill_emit = go || (state_reg == ST_FILL);

    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_IDLE) begin
            if (go && fill_cnt_reg != 16'd1) state_next = ST_FILL;
        end else if (fill_cnt_reg == 16'd1) begin
            state_next = ST_IDLE;
        end
    end

    vga_fb_pointer #(.FB_ADDR_W(FB_ADDR_W), .FB_DEPTH(FB_DEPTH)) u_ptr (
        .clk      (clk),
        .reset    (reset),
        .load_hi  (wr_cfg && offset == REG_PTR_HI),
        .load_lo  (wr_cfg && offset == REG_PTR_LO),
        .load_data(wdata),
        .inc      (fill_emit || (data_emit && ainc_reg)),
        .ptr      (ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            busy_reg     <= 1'b0;
            ainc_reg     <= 1'b1;
            colour_reg   <= '0;
            fill_cnt_reg <= '0;
            fb_addr_reg  <= '0;
            fb_data_reg  <= '0;
            fb_we_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= fill_emit;
            fb_we_reg <= fill_emit || data_emit;
            if (fill_emit || data_emit) begin
                fb_addr_reg <= ptr;
                fb_data_reg <= fill_emit ? colour_reg : wdata[PIX_W-1:0];
            end
            if (data_emit) colour_reg <= wdata[PIX_W-1:0];
            if (wr_acc && offset == REG_CTRL) ainc_reg <= wdata[CTRL_AINC_BIT];
            if (fill_emit) begin
                fill_cnt_reg <= fill_cnt_reg - 16'd1;
            end else if (wr_cfg && offset == REG_CNT_LO) begin
                fill_cnt_reg[7:0] <= wdata;
            end else if (wr_cfg && offset == REG_CNT_HI) begin
                fill_cnt_reg[15:8] <= wdata;
            end
        end
    end

    assign fb_addr = fb_addr_reg;
    assign fb_data = fb_data_reg;
    assign fb_we   = fb_we_reg;
    assign busy    = busy_reg;

`ifdef VGA_FB_READBACK_EN
    logic [15:0] ptr_wide;
    logic [7:0]  rd_word;
    logic [7:0]  rd_data_reg;
    logic        rd_oe_reg;

    assign ptr_wide = 16'(ptr);

    always_comb begin
        rd_word = 8'h00;
        case (offset)
            REG_PTR_HI: rd_word = ptr_wide[15:8];
            REG_PTR_LO: rd_word = ptr_wide[7:0];
            REG_DATA:   rd_word = 8'(colour_reg);
            REG_CTRL:   rd_word = {7'b0, ainc_reg};
            REG_CNT_LO: rd_word = fill_cnt_reg[7:0];
            REG_CNT_HI: rd_word = fill_cnt_reg[15:8];
            REG_STATUS: rd_word = {7'b0, busy_reg};
            default:    rd_word = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_oe_reg   <= 1'b0;
            rd_data_reg <= 8'h00;
        end else begin
            rd_oe_reg   <= !bus.bus_we && in_range;
            rd_data_reg <= rd_word;
        end
    end

    assign bus.bus_data = rd_oe_reg ? rd_data_reg : 8'hzz;
`else
    // Write-only build: bus_data stays undriven here so the host owns it every cycle.
`endif

endmodule

// File: tb/tb_vga_fb_bus_writer.sv
// Self-checking bench for vga_fb_bus_writer: per-cycle model compare plus directed literal checks.
module tb_vga_fb_bus_writer;
    localparam logic [7:0] BASE  = 8'hB0;
    localparam int         AW    = 15;
    localparam int         DEPTH = 19200;
    localparam int         PW    = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] fb_addr;
    logic [PW-1:0] fb_data;
    logic          fb_we;
    logic          busy;

    int checks = 0;
    int errors = 0;

    vga_fb_bus_writer_if bus_if ();

    vga_fb_bus_writer #(.BASE_ADDR(BASE), .FB_ADDR_W(AW), .FB_DEPTH(DEPTH), .PIX_W(PW)) dut (
        .clk    (clk),
        .reset  (rst),
        .bus    (bus_if),
        .fb_addr(fb_addr),
        .fb_data(fb_data),
        .fb_we  (fb_we),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: registers as plain integers, fill tracked as pixels remaining.
    int m_ptr, m_colour, m_ainc, m_cnt;
    int exp_we, exp_addr, exp_data, exp_busy;
    bit chk_en = 0;

    function automatic int wrap_inc(input int p);
        return (p >= DEPTH - 1) ? 0 : p + 1;
    endfunction

    task automatic emit_fill();
        exp_we   = 1;
        exp_addr = m_ptr;
        exp_data = m_colour;
        exp_busy = 1;
        m_ptr    = wrap_inc(m_ptr);
        m_cnt    = m_cnt - 1;
    endtask

    always @(posedge clk) begin
        int  off, d;
        bit  busy_now, filling;
        if (rst) begin
            m_ptr = 0; m_colour = 0; m_ainc = 1; m_cnt = 0;
            exp_we = 0; exp_addr = 0; exp_data = 0; exp_busy = 0;
            chk_en = 1;
        end else begin
            busy_now = (exp_busy != 0);
            filling  = busy_now && (m_cnt > 0);
            exp_we   = 0;
            exp_busy = 0;
            if (filling) emit_fill();
            d = int'(bus_if.host_data);
            if (bus_if.bus_we && bus_if.bus_addr >= BASE && int'(bus_if.bus_addr) < int'(BASE) + 8) begin
                off = int'(bus_if.bus_addr) - int'(BASE);
                case (off)
                    0: if (!busy_now) m_ptr = (m_ptr & 'hFF) | ((d & ((1 << (AW - 8)) - 1)) << 8);
                    1: if (!busy_now) m_ptr = (m_ptr & ~'hFF) | d;
                    2: if (!busy_now) begin
                        m_colour = d & ((1 << PW) - 1);
                        exp_we   = 1;
                        exp_addr = m_ptr;
                        exp_data = m_colour;
                        if (m_ainc != 0) m_ptr = wrap_inc(m_ptr);
                    end
                    3: begin
                        m_ainc = d & 1;
                        if (((d >> 1) & 1) != 0 && !busy_now && m_cnt != 0) emit_fill();
                    end
                    4: if (!busy_now) m_cnt = (m_cnt & 'hFF00) | d;
                    5: if (!busy_now) m_cnt = (m_cnt & 'h00FF) | (d << 8);
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_fb_we", int'(fb_we), exp_we);
            chk("model_busy", int'(busy), exp_busy);
            if (exp_we != 0) begin
                chk("model_fb_addr", int'(fb_addr), exp_addr);
                chk("model_fb_data", int'(fb_data), exp_data);
            end
        end
    end

    // Called at a negedge; returns at the next negedge with the write's effect visible.
    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bus_if.bus_addr  = a;
        bus_if.bus_we    = 1'b1;
        bus_if.host_data = d;
        bus_if.host_oe   = 1'b1;
        @(negedge clk);
        bus_if.bus_we  = 1'b0;
        bus_if.host_oe = 1'b0;
        $display("bus write addr=0x%02h data=0x%02h -> fb_we=%0d fb_addr=0x%04h fb_data=%0d busy=%0d",
                 a, d, fb_we, fb_addr, fb_data, busy);
    endtask

`ifdef VGA_FB_READBACK_EN
    task automatic bus_rd(input logic [7:0] a, input int exp, input string name);
        bus_if.bus_addr = a;
        bus_if.bus_we   = 1'b0;
        bus_if.host_oe  = 1'b0;
        @(negedge clk);
        $display("bus read  addr=0x%02h -> data=0x%02h", a, bus_if.bus_data);
        chk(name, int'(bus_if.bus_data), exp);
        bus_if.bus_addr = 8'h00;
    endtask
`endif

    initial begin
        bus_if.bus_addr  = 8'h00;
        bus_if.bus_we    = 1'b0;
        bus_if.host_data = 8'h00;
        bus_if.host_oe   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_fb_we", int'(fb_we), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fb_addr", int'(fb_addr), 0);
        chk("reset_fb_data", int'(fb_data), 0);

        // Single DATA write with auto-increment.
        bus_wr(8'hB0, 8'h09);
        bus_wr(8'hB1, 8'h61);
        bus_wr(8'hB2, 8'h01);
        chk("t1_fb_we", int'(fb_we), 1);
        chk("t1_fb_addr", int'(fb_addr), 'h0961);
        chk("t1_fb_data", int'(fb_data), 1);
        chk("t1_model_ptr", m_ptr, 'h0962);
        @(negedge clk);
        chk("t1_we_drop", int'(fb_we), 0);

        // AINC off: repeated writes hit the same pixel.
        bus_wr(8'hB3, 8'h00);
        bus_wr(8'hB2, 8'h01);
        chk("t2_addr_a", int'(fb_addr), 'h0962);
        bus_wr(8'hB2, 8'h01);
        chk("t2_addr_b", int'(fb_addr), 'h0962);
        bus_wr(8'hB3, 8'h01);

        // Wrap at FB_DEPTH-1 (19199 = 0x4AFF).
        bus_wr(8'hB0, 8'h4A);
        bus_wr(8'hB1, 8'hFF);
        bus_wr(8'hB2, 8'h00);
        chk("t3_addr_last", int'(fb_addr), 19199);
        chk("t3_data_last", int'(fb_data), 0);
        bus_wr(8'hB2, 8'h01);
        chk("t3_addr_wrap", int'(fb_addr), 0);

        // Out-of-range pointer (upper PTR_HI bit dropped) wraps on next increment.
        bus_wr(8'hB0, 8'hFF);
        bus_wr(8'hB1, 8'hFF);
        bus_wr(8'hB2, 8'h01);
        chk("oor_addr", int'(fb_addr), 'h7FFF);
        bus_wr(8'hB2, 8'h01);
        chk("oor_wrap", int'(fb_addr), 0);

        // Addresses outside the window and the reserved register do nothing.
        bus_wr(8'hB8, 8'h01);
        chk("oor_bus_hi", int'(fb_we), 0);
        bus_wr(8'hAF, 8'h01);
        chk("oor_bus_lo", int'(fb_we), 0);
        bus_wr(8'hB7, 8'hFF);

        // FILL with zero count never starts.
        bus_wr(8'hB4, 8'h00);
        bus_wr(8'hB5, 8'h00);
        bus_wr(8'hB3, 8'h03);
        chk("cnt0_we", int'(fb_we), 0);
        chk("cnt0_busy", int'(busy), 0);

        // Five-pixel FILL from 0x0100.
        bus_wr(8'hB2, 8'h01);
        bus_wr(8'hB0, 8'h01);
        bus_wr(8'hB1, 8'h00);
        bus_wr(8'hB4, 8'h05);
        bus_wr(8'hB5, 8'h00);
        bus_wr(8'hB3, 8'h03);
        for (int i = 0; i < 5; i++) begin
            chk("t4_we", int'(fb_we), 1);
            chk("t4_busy", int'(busy), 1);
            chk("t4_addr", int'(fb_addr), 'h0100 + i);
            if (i < 4) @(negedge clk);
        end
        @(negedge clk);
        chk("t4_done_we", int'(fb_we), 0);
        chk("t4_done_busy", int'(busy), 0);
        chk("t4_model_ptr", m_ptr, 'h0105);
        bus_wr(8'hB2, 8'h01);
        chk("t4_next_addr", int'(fb_addr), 'h0105);

        // FILL across the wrap point, with AINC cleared while busy.
        bus_wr(8'hB0, 8'h4A);
        bus_wr(8'hB1, 8'hFE);
        bus_wr(8'hB4, 8'h03);
        bus_wr(8'hB3, 8'h03);
        bus_wr(8'hB3, 8'h02);
        bus_wr(8'hB1, 8'h33);
        chk("wrapfill_addr", int'(fb_addr), 0);
        @(negedge clk);
        bus_wr(8'hB2, 8'h01);
        chk("ainc_busy_a", int'(fb_addr), 1);
        bus_wr(8'hB2, 8'h01);
        chk("ainc_busy_b", int'(fb_addr), 1);
        bus_wr(8'hB3, 8'h01);

`ifdef VGA_FB_READBACK_EN
        bus_wr(8'hB4, 8'h14);
        bus_wr(8'hB3, 8'h03);
        bus_rd(8'hB6, 'h01, "rb_status_busy");
        repeat (25) @(negedge clk);
        bus_rd(8'hB6, 'h00, "rb_status_idle");
        bus_rd(8'hB0, (m_ptr >> 8) & 'hFF, "rb_ptr_hi");
`endif

        // Long FILL: mid-fill writes ignored, then reset at pixel 10.
        bus_wr(8'hB0, 8'h00);
        bus_wr(8'hB1, 8'h10);
        bus_wr(8'hB4, 8'hE8);
        bus_wr(8'hB5, 8'h03);
        bus_wr(8'hB3, 8'h03);
        bus_wr(8'hB1, 8'h55);
        bus_wr(8'hB2, 8'h00);
        bus_wr(8'hB0, 8'h02);
        bus_wr(8'hB4, 8'h01);
        repeat (6) @(negedge clk);
        chk("t5_pix10_addr", int'(fb_addr), 'h001A);
        chk("t5_pix10_data", int'(fb_data), 1);
        chk("t5_pix10_busy", int'(busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_we", int'(fb_we), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_addr", int'(fb_addr), 0);
        repeat (3) @(negedge clk);
        chk("t5_quiet", int'(fb_we), 0);
        bus_wr(8'hB2, 8'h01);
        chk("t5_after_addr", int'(fb_addr), 0);
        bus_wr(8'hB2, 8'h01);
        chk("t5_after_ainc", int'(fb_addr), 1);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
